// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake; iterative divider built only when ALU_MC_DIV_EN is defined
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;     // multiplicand (MUL) or dividend/quotient shifter (DIV)
    logic [WIDTH-1:0] b_q, b_d;     // multiplier shifter (MUL) or divisor (DIV)
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d; // product accumulator (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] c_q, c_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] alu_res;
    logic             is_multi;
    logic             accept;
    logic [WIDTH-1:0] res_fin;
`ifdef ALU_MC_DIV_EN
    logic [WIDTH:0]   trial;
`endif

    assign out_valid = (state_q == DONE);
    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign c         = c_q;
    assign zero      = zero_q;

    // Single-cycle result straight from the live operands, used on acceptance
    always_comb begin
        logic [SHW-1:0] sh;
        sh       = b[SHW-1:0];
        alu_res  = '0;
        is_multi = (ALUC == OP_MUL);
`ifdef ALU_MC_DIV_EN
        is_multi = is_multi || (ALUC == OP_DIVU) || (ALUC == OP_REMU);
`endif
        case (ALUC)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  alu_res = a << sh;
            OP_SRL:  alu_res = a >> sh;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> sh);
            default: alu_res = '0;
        endcase
    end

    // Next-state, operand capture and one iteration step per BUSY cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        c_d     = c_q;
        zero_d  = zero_q;
        res_fin = '0;
`ifdef ALU_MC_DIV_EN
        trial   = '0;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d  = a;
                    b_d  = b;
                    op_d = ALUC;
                    if (is_multi) begin
                        state_d = BUSY;
                        cnt_d   = CW'(WIDTH);
                        acc_d   = '0;
                    end else begin
                        state_d = DONE;
                        c_d     = alu_res;
                        zero_d  = (alu_res == '0);
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (op_q == OP_MUL) begin
                    acc_d   = b_q[0] ? (acc_q + a_q) : acc_q;
                    a_d     = a_q << 1;
                    b_d     = b_q >> 1;
                    res_fin = acc_d;
                end
`ifdef ALU_MC_DIV_EN
                else begin
                    // Restoring step: shift next dividend bit into the remainder, subtract if it fits
                    trial = {acc_q, a_q[WIDTH-1]} - {1'b0, b_q};
                    if (!trial[WIDTH]) begin
                        acc_d = trial[WIDTH-1:0];
                        a_d   = {a_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[WIDTH-2:0], a_q[WIDTH-1]};
                        a_d   = {a_q[WIDTH-2:0], 1'b0};
                    end
                    res_fin = (op_q == OP_DIVU) ? a_d : acc_d;
                end
`endif
                cnt_d = cnt_q - 1'b1;
                // Last step writes the result on the same edge it completes
                if (cnt_q == CW'(1)) begin
                    c_d     = res_fin;
                    zero_d  = (res_fin == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            c_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc against a behavioural model
module tb_alu_mc;
    localparam int W = 32;
`ifdef ALU_MC_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   ALUC = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] c;
    logic         zero;

    int n_pass = 0;
    int n_total = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUC(ALUC), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned     sh;
        longint unsigned prod;
        sh = y % W;
        case (op)
            4'd0:  return x + y;
            4'd1:  return x - y;
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return x ^ y;
            4'd5:  return (x < y) ? W'(1) : W'(0);
            4'd6:  return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
            4'd7:  return x << sh;
            4'd8:  return x >> sh;
            4'd9:  return W'($signed(x) >>> sh);
            4'd10: begin
                prod = 64'(x) * 64'(y);
                return prod[W-1:0];
            end
            4'd11: return !DIV_EN ? W'(0) : (y == 0) ? '1 : x / y;
            4'd12: return !DIV_EN ? W'(0) : (y == 0) ? x : x % y;
            default: return '0;
        endcase
    endfunction

    function automatic int lat_of(input logic [3:0] op);
        if (op == 4'd10 || (DIV_EN && (op == 4'd11 || op == 4'd12))) return W + 1;
        return 1;
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge where the result is visible
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] e);
        int g;
        int n;
        int rdy_busy;
        a = x; b = y; ALUC = op; in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; ALUC = 4'($urandom);
        n = 1;
        rdy_busy = 0;
        while (!out_valid && n < 200) begin
            if (in_ready) rdy_busy++;
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(lat_of(op)));
        chk({tag, "_c"}, 64'(c), 64'(e));
        chk({tag, "_zero"}, 64'(zero), 64'(e == '0));
        chk({tag, "_busy_ready"}, 64'(rdy_busy), 64'(0));
    endtask

    initial begin
        logic [W-1:0] held;
        logic [3:0]   rop;
        logic [W-1:0] rx, ry;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_c", 64'(c), 64'(0));
        chk("rst_zero", 64'(zero), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Directed cases
        run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_op("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
        run_op("slt", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd1);
        run_op("sltu", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_op("sra", 4'd9, 32'h8000_0000, 32'h24, 32'hF800_0000);
        run_op("sll31", 4'd7, 32'd1, 32'd31, 32'h8000_0000);
        run_op("srl31", 4'd8, 32'h8000_0000, 32'd31, 32'd1);
        run_op("op13", 4'd13, 32'd12, 32'd34, 32'd0);
        run_op("mul", 4'd10, 32'd7, 32'd6, 32'd42);
        run_op("mul_ovf", 4'd10, 32'h1_0000, 32'h1_0000, 32'd0);
        run_op("divu", 4'd11, 32'd100, 32'd7, DIV_EN ? 32'd14 : 32'd0);
        run_op("remu", 4'd12, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'd0);
        run_op("divu0", 4'd11, 32'd9, 32'd0, DIV_EN ? 32'hFFFF_FFFF : 32'd0);
        run_op("remu0", 4'd12, 32'd9, 32'd0, DIV_EN ? 32'd9 : 32'd0);

        // Stall with out_ready low, then back-to-back accept on release
        @(posedge clk); #1;
        out_ready = 1'b0;
        run_op("stall_add", 4'd0, 32'd20, 32'd22, 32'd42);
        held = c;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_c", 64'(c), 64'(held));
            chk("stall_in_ready", 64'(in_ready), 64'(0));
        end
        out_ready = 1'b1;
        run_op("b2b_xor", 4'd4, 32'hF0, 32'hFF, 32'h0F);

        // Reset in the middle of a multiply
        a = 32'd7; b = 32'd6; ALUC = 4'd10; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'(0));
        chk("midrst_c", 64'(c), 64'(0));
        chk("midrst_zero", 64'(zero), 64'(0));
        @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", 64'(in_ready), 64'(1));
        chk("midrst_idle", 64'(out_valid), 64'(0));
        run_op("post_rst_add", 4'd0, 32'd2, 32'd3, 32'd5);

        // Randomized operations against the model
        for (int k = 0; k < 150; k++) begin
            rop = 4'($urandom_range(0, 15));
            rx  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
            case ($urandom_range(0, 3))
                0:       ry = '0;
                1:       ry = 32'($urandom_range(0, 40));
                default: ry = 32'($urandom);
            endcase
            run_op("rand", rop, rx, ry, model(rop, rx, ry));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
